mem_access_ctrl: RTL and testbench

Memory-stage load/store controller sitting directly downstream of the main decoder. It consumes the decoder's `memtoreg`, `memwrite` and 3-bit `fc` access code, and drives a single-outstanding SRAM-like data bus. It returns sign- or zero-extended load data and raises a pipeline stall while the access is in flight. Misaligned accesses are trapped as address errors before any bus request is issued.

---
 rtl/mem_access_ctrl.sv | 137 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: traps misaligned accesses, drives a
// single-outstanding SRAM-like data bus and returns extended load data.
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memtoreg,
  input  logic              memwrite,
  input  logic [2:0]        fc,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] badvaddr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  state_t state, state_nx;

  logic        mem_en, is_store, mis, go, discard;
  logic [1:0]  size;
  logic [2:0]  fc_q;
  logic [1:0]  a_q;
  logic [31:0] fmt_wdata, ext;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign mem_en   = (memtoreg | memwrite) & ~flush;
  assign is_store = fc[2] & (fc[1] | fc[0]);

  always_comb begin
    size = 2'd0;
    case (fc)
      3'b010, 3'b011, 3'b110: size = 2'd1;
      3'b100, 3'b111:         size = 2'd2;
      default:                size = 2'd0;
    endcase
  end

  assign mis      = ((size == 2'd1) & addr[0]) | ((size == 2'd2) & (|addr[1:0]));
  assign go       = (state == S_IDLE) & mem_en & ~mis;
  assign adel     = (state == S_IDLE) & mem_en & mis & ~is_store;
  assign ades     = (state == S_IDLE) & mem_en & mis & is_store;
  assign badvaddr = addr;

  always_comb begin
    fmt_wdata = wdata;
    case (size)
      2'd0:    fmt_wdata = {4{wdata[7:0]}};
      2'd1:    fmt_wdata = {2{wdata[15:0]}};
      default: fmt_wdata = wdata;
    endcase
  end

  // Load extraction keys off the address/code captured at issue, not the live inputs.
  assign lane_b = data_rdata[{a_q, 3'b000} +: 8];
  assign lane_h = a_q[1] ? data_rdata[31:16] : data_rdata[15:0];

  always_comb begin
    ext = data_rdata;
    case (fc_q)
      3'b000:  ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  ext = {24'h0, lane_b};
      3'b010:  ext = {{16{lane_h[15]}}, lane_h};
      3'b011:  ext = {16'h0, lane_h};
      default: ext = data_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (go) state_nx = S_REQ;
      S_REQ: begin
        if (data_addr_ok) state_nx = S_WAIT;
        else if (flush)   state_nx = S_IDLE;
      end
      S_WAIT: if (data_data_ok) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Stall is forced low under reset so the pipeline is released immediately.
  always_comb begin
    stall       = ~rst & (go | (state == S_REQ) | (state == S_WAIT));
    rdata_valid = (state == S_DONE) & ~data_wr & ~discard;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= '0;
      data_wdata <= 32'h0;
      fc_q       <= 3'd0;
      a_q        <= 2'd0;
      rdata      <= 32'h0;
      discard    <= 1'b0;
    end else begin
      data_req <= (state_nx == S_REQ);
      if (go) begin
        data_addr  <= addr;
        data_size  <= size;
        data_wr    <= is_store;
        data_wdata <= fmt_wdata;
        fc_q       <= fc;
        a_q        <= addr[1:0];
      end
      if ((state == S_WAIT) && data_data_ok) rdata <= ext;
      if (state_nx == S_IDLE)
        discard <= 1'b0;
      else if (((state == S_REQ) && data_addr_ok && flush) || ((state == S_WAIT) && flush))
        discard <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, flush/reset
// sequences, and randomized accesses against a spec-level reference model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        memtoreg, memwrite, flush;
  logic [2:0]  fc;
  logic [31:0] addr, wdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid, adel, ades;
  logic [31:0] badvaddr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .memtoreg(memtoreg), .memwrite(memwrite), .fc(fc),
    .flush(flush), .addr(addr), .wdata(wdata), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .stall(stall),
    .rdata(rdata), .rdata_valid(rdata_valid), .adel(adel), .ades(ades),
    .badvaddr(badvaddr)
  );

  typedef struct {
    logic [2:0]  fc;
    logic [31:0] addr, wdata, raw;
    int          aok, dok;
    bit          flw;
    logic [31:0] e_rd, e_wd;
    logic [1:0]  e_sz, e_err;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%b exp=%b", nm, act, exp);
    end
  endtask

  // Reference model: plain arithmetic from the access-code rules.
  function automatic logic [1:0] m_size(input logic [2:0] f);
    if (f == 3'd0 || f == 3'd1 || f == 3'd5) return 2'd0;
    if (f == 3'd2 || f == 3'd3 || f == 3'd6) return 2'd1;
    return 2'd2;
  endfunction

  function automatic bit m_mis(input logic [2:0] f, input logic [31:0] a);
    int sz = int'(m_size(f));
    return (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] m_wfmt(input logic [2:0] f, input logic [31:0] w);
    int sz = int'(m_size(f));
    if (sz == 0) return (w & 32'hFF) * 32'h01010101;
    if (sz == 1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] raw);
    int unsigned off = a % 4;
    logic [31:0] b = (raw >> (8 * off)) & 32'hFF;
    logic [31:0] h = (raw >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
    case (f)
      3'd0: return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'd1: return b;
      3'd2: return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'd3: return h;
      default: return raw;
    endcase
  endfunction

  task automatic run_txn(input logic [2:0] f, input logic [31:0] a, wd, raw,
                         input int aok, dok, input bit flw,
                         input logic [31:0] e_rd, e_wd, input logic [1:0] e_sz, e_err);
    bit st = (f >= 3'd5);
    @(posedge clk); #1;
    memtoreg = !st; memwrite = st; fc = f; addr = a; wdata = wd;
    data_addr_ok = 0; data_data_ok = 0; flush = 0;
    @(negedge clk);
    if (e_err != 2'd0) begin
      chk1("err_adel", adel, e_err == 2'd1);
      chk1("err_ades", ades, e_err == 2'd2);
      chk("err_badvaddr", badvaddr, a);
      chk1("err_stall", stall, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk1("err_noreq", data_req, 1'b0);
      memtoreg = 0; memwrite = 0;
      return;
    end
    chk1("c0_stall", stall, 1'b1);
    chk1("c0_noerr", adel | ades, 1'b0);
    chk1("c0_noreq", data_req, 1'b0);
    // Slave also pulses data_data_ok in the accept cycle; the DUT must ignore it.
    for (int k = 0; k <= aok; k++) begin
      @(posedge clk); #1;
      data_addr_ok = (k == aok); data_data_ok = (k == aok); data_rdata = $urandom;
      @(negedge clk);
      chk1("req_req", data_req, 1'b1);
      chk1("req_stall", stall, 1'b1);
      chk("req_addr", data_addr, a);
      chk("req_size", 32'(data_size), 32'(e_sz));
      chk1("req_wr", data_wr, st);
      if (st) chk("req_wdata", data_wdata, e_wd);
    end
    for (int k = 0; k <= dok; k++) begin
      @(posedge clk); #1;
      data_addr_ok = 0; data_data_ok = (k == dok);
      data_rdata = (k == dok) ? raw : $urandom;
      flush = flw && (k == 0);
      @(negedge clk);
      chk1("wait_noreq", data_req, 1'b0);
      chk1("wait_stall", stall, 1'b1);
      chk1("wait_valid", rdata_valid, 1'b0);
    end
    @(posedge clk); #1;
    data_data_ok = 0; flush = 0; data_rdata = $urandom;
    @(negedge clk);
    chk1("done_stall", stall, 1'b0);
    chk1("done_noreq", data_req, 1'b0);
    chk1("done_valid", rdata_valid, !st && !flw);
    if (!st && !flw) chk("done_rdata", rdata, e_rd);
    @(posedge clk); #1;
    memtoreg = 0; memwrite = 0;
    @(negedge clk);
    chk1("post_noreq", data_req, 1'b0);
  endtask

  initial begin
    vt[0]  = '{3'd4, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1, 1'b0, 32'hDEADBEEF, 32'h0,        2'd2, 2'd0};
    vt[1]  = '{3'd0, 32'h103, 32'h0,        32'h80FF0000, 1, 0, 1'b0, 32'hFFFFFF80, 32'h0,        2'd0, 2'd0};
    vt[2]  = '{3'd1, 32'h103, 32'h0,        32'h80FF0000, 0, 0, 1'b0, 32'h00000080, 32'h0,        2'd0, 2'd0};
    vt[3]  = '{3'd2, 32'h102, 32'h0,        32'h80011234, 0, 2, 1'b0, 32'hFFFF8001, 32'h0,        2'd1, 2'd0};
    vt[4]  = '{3'd3, 32'h100, 32'h0,        32'h80011234, 2, 0, 1'b0, 32'h00001234, 32'h0,        2'd1, 2'd0};
    vt[5]  = '{3'd5, 32'h201, 32'h000000A5, 32'h0,        0, 0, 1'b0, 32'h0,        32'hA5A5A5A5, 2'd0, 2'd0};
    vt[6]  = '{3'd6, 32'h201, 32'h0000BEEF, 32'h0,        0, 0, 1'b0, 32'h0,        32'h0,        2'd1, 2'd2};
    vt[7]  = '{3'd4, 32'h102, 32'h0,        32'h0,        0, 0, 1'b0, 32'h0,        32'h0,        2'd2, 2'd1};
    vt[8]  = '{3'd6, 32'h202, 32'h1234BEEF, 32'h0,        1, 1, 1'b0, 32'h0,        32'hBEEFBEEF, 2'd1, 2'd0};
    vt[9]  = '{3'd7, 32'h204, 32'h12345678, 32'h0,        0, 0, 1'b0, 32'h0,        32'h12345678, 2'd2, 2'd0};
    vt[10] = '{3'd0, 32'h101, 32'h0,        32'h00007F00, 0, 0, 1'b0, 32'h0000007F, 32'h0,        2'd0, 2'd0};
    vt[11] = '{3'd4, 32'h108, 32'h0,        32'hCAFEF00D, 0, 1, 1'b1, 32'h0,        32'h0,        2'd2, 2'd0};

    rst = 1; memtoreg = 0; memwrite = 0; flush = 0; fc = 3'd4; addr = 32'h2; wdata = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    #1 memtoreg = 1;
    #1;
    chk1("rst_adel", adel, 1'b1);
    chk("rst_badvaddr", badvaddr, 32'h2);
    chk1("rst_stall", stall, 1'b0);
    @(negedge clk);
    chk1("rst_req", data_req, 1'b0);
    chk1("rst_valid", rdata_valid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_daddr", data_addr, 32'h0);
    chk("rst_wdata", data_wdata, 32'h0);
    memtoreg = 0; addr = 0;
    @(posedge clk); #1 rst = 0;

    foreach (vt[i])
      run_txn(vt[i].fc, vt[i].addr, vt[i].wdata, vt[i].raw, vt[i].aok, vt[i].dok,
              vt[i].flw, vt[i].e_rd, vt[i].e_wd, vt[i].e_sz, vt[i].e_err);

    // Flush while the request is still pending: request withdrawn, no WAIT.
    @(posedge clk); #1;
    memtoreg = 1; fc = 3'd4; addr = 32'h300; data_addr_ok = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("freq_req", data_req, 1'b1);
    flush = 1;
    @(posedge clk); #1;
    flush = 0; memtoreg = 0;
    @(negedge clk);
    chk1("freq_drop", data_req, 1'b0);
    chk1("freq_stall", stall, 1'b0);
    data_addr_ok = 1;
    @(posedge clk); #1 data_addr_ok = 0;
    @(negedge clk);
    chk1("freq_idle", stall, 1'b0);

    // Reset while waiting for read data.
    @(posedge clk); #1;
    memtoreg = 1; fc = 3'd4; addr = 32'h400;
    @(posedge clk); #1 data_addr_ok = 1;
    @(posedge clk); #1 data_addr_ok = 0;
    @(negedge clk);
    chk1("rwait_stall", stall, 1'b1);
    #1 rst = 1;
    #1;
    chk1("rwait_stall0", stall, 1'b0);
    chk1("rwait_req0", data_req, 1'b0);
    chk("rwait_daddr", data_addr, 32'h0);
    memtoreg = 0;
    @(posedge clk); #1 rst = 0;
    run_txn(3'd4, 32'h400, 32'h0, 32'h13579BDF, 0, 0, 1'b0, 32'h13579BDF, 32'h0, 2'd2, 2'd0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f   = 3'($urandom_range(0, 7));
      logic [31:0] a   = $urandom & 32'hFFFF_FFFC;
      logic [31:0] wd  = $urandom;
      logic [31:0] raw = $urandom;
      int  aok = $urandom_range(0, 3);
      int  dok = $urandom_range(0, 3);
      bit  flw = ($urandom_range(0, 4) == 0);
      bit  st  = (f >= 3'd5);
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(0, 3));
      else if (m_size(f) == 2'd0)    a = a | 32'($urandom_range(0, 3));
      else if (m_size(f) == 2'd1)    a = a | (32'($urandom_range(0, 1)) << 1);
      run_txn(f, a, wd, raw, aok, dok, flw, m_load(f, a, raw), m_wfmt(f, wd), m_size(f),
              m_mis(f, a) ? (st ? 2'd2 : 2'd1) : 2'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
